// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: FSM state encoding and load-byte modes.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] LB_WORD = 2'b00;
  localparam logic [1:0] LB_U    = 2'b01;
  localparam logic [1:0] LB_S    = 2'b10;

endpackage

// File: rtl/byte_extract.sv
// Big-endian byte select with zero/sign extension for LBU/LB; word mode passes through.
module byte_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  mode,
  output logic [31:0] value
);

  logic [7:0] byte_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    byte_sel = rdata[31:24];
    value    = rdata;
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    case (mode)
      LB_U:    value = {24'h0, byte_sel};
      LB_S:    value = {{24{byte_sel[7]}}, byte_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns single-cycle controller read/write strobes into a req/ack memory handshake,
// stalling the controller until completion and owning the IR and MDR.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          irwrite,
  input  logic [1:0]    lb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] data,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            irwrite_q;
  logic [1:0]      lb_q, off_q;
  logic            mem_req_q, mem_we_q, err_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, instr_q, data_q;
  logic [31:0]     data_d;
  logic            timeout_hit;

  byte_extract u_byte_extract (
    .rdata  (mem_rdata),
    .offset (off_q),
    .mode   (lb_q),
    .value  (data_d)
  );

  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // DONE drops stall for one cycle so the controller advances exactly once.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = rd_req | wr_req;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      irwrite_q   <= 1'b0;
      lb_q        <= LB_WORD;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req || wr_req) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= wr_req;
            mem_addr_q  <= {addr[AW-1:2], 2'b00};
            mem_wdata_q <= wdata;
            irwrite_q   <= irwrite;
            lb_q        <= lb;
            off_q       <= addr[1:0];
            cnt_q       <= '0;
            // Conflicting strobes: the write proceeds, the read is dropped and flagged.
            if (rd_req && wr_req) err_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_d;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_we_q) begin
              if (irwrite_q) instr_q <= mem_rdata;
              else           data_q  <= DW'(data_d);
            end
            state_q <= DONE;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr     = instr_q;
  assign data      = data_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner sequences, randomized model check.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req, wr_req, irwrite;
  logic [1:0]  lb;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] instr, data;
  logic        err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .irwrite   (irwrite),
    .lb        (lb),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .instr     (instr),
    .data      (data),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, irw;
    logic [1:0]  lbm;
    logic [31:0] a, wd, rdat;
    int          waits;
    logic [31:0] e_instr, e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference byte load: shift the addressed big-endian byte down, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] mode);
    int unsigned b;
    int          s;
    b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
    if (mode == 2'b01) return 32'(b);
    if (mode == 2'b10) begin
      s = (b >= 128) ? int'(b) - 256 : int'(b);
      return 32'(s);
    end
    return w;
  endfunction

  // Starts at a falling edge with the DUT idle; ends at a falling edge with the DUT idle again.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic irw,
                            input logic [1:0] lbm, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int waits,
                            input logic [31:0] e_instr, input logic [31:0] e_data,
                            input logic e_err);
    int nb;
    nb = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    rd_req = rd; wr_req = wr; irwrite = irw; lb = lbm; addr = a; wdata = wd;
    #1;
    check({tag, ":idle_stall"}, 32'(stall), 32'd1);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      check({tag, ":busy_req"},   32'(mem_req),  32'd1);
      check({tag, ":busy_stall"}, 32'(stall),    32'd1);
      check({tag, ":busy_we"},    32'(mem_we),   32'(wr));
      check({tag, ":busy_addr"},  mem_addr,      {a[31:2], 2'b00});
      check({tag, ":busy_wdata"}, mem_wdata,     wd);
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdat : $urandom();
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom();
    check({tag, ":done_stall"}, 32'(stall),   32'd0);
    check({tag, ":done_req"},   32'(mem_req), 32'd0);
    check({tag, ":instr"},      instr,        e_instr);
    check({tag, ":data"},       data,         e_data);
    check({tag, ":err"},        32'(err),     32'(e_err));
    // Strobes were still high through DONE; they must not have launched a new access.
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    check({tag, ":idle_req"},   32'(mem_req), 32'd0);
    check({tag, ":idle_stall0"}, 32'(stall),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_err;
    logic [31:0] m_instr, m_data;
    logic        r_rd, r_wr, r_irw;
    logic [1:0]  r_lb;
    logic [31:0] r_a, r_wd, r_rdat;
    int          r_waits, kind;
    int          wait_pick [7] = '{0, 1, 2, 3, 13, 14, 15};

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h40,  32'h0,         32'h2008_0005, 0, 32'h2008_0005, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h45,  32'h0,         32'h1280_FF34, 3, 32'h2008_0005, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h45,  32'h0,         32'h1280_FF34, 3, 32'h2008_0005, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h50,  32'hDEAD_BEEF, 32'h5555_5555, 2, 32'h2008_0005, 32'h0000_0080, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h103, 32'h0,         32'h0000_00F0, 1, 32'h2008_0005, 32'hFFFF_FFF0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h22,  32'h0,         32'h0000_A500, 0, 32'h2008_0005, 32'h0000_00A5, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h22,  32'h0,         32'h1234_7FAB, 2, 32'h2008_0005, 32'h0000_007F, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h7,   32'h0,         32'hCAFE_F00D, 0, 32'h2008_0005, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h1,   32'h0,         32'h1234_5678, 1, 32'h2008_0005, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h200, 32'h0,         32'h80FF_FFFF, 0, 32'h2008_0005, 32'hFFFF_FF80, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h3C,  32'h0,         32'h8C22_0004, 0, 32'h8C22_0004, 32'hFFFF_FF80, 1'b0};

    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; irwrite = 1'b0; lb = 2'b00;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we),  32'd0);
    check("rst_addr",  mem_addr,     32'd0);
    check("rst_wdata", mem_wdata,    32'd0);
    check("rst_instr", instr,        32'd0);
    check("rst_data",  data,         32'd0);
    check("rst_err",   32'(err),     32'd0);
    check("rst_stall", 32'(stall),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table; consecutive rows also exercise back-to-back launches from IDLE.
    for (int i = 0; i < 11; i++)
      run_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].irw, vecs[i].lbm,
                 vecs[i].a, vecs[i].wd, vecs[i].rdat, vecs[i].waits,
                 vecs[i].e_instr, vecs[i].e_data, vecs[i].e_err);

    // Timeout: no ack for TIMEOUT busy cycles, then err is sticky across good accesses.
    run_access("timeout", 1'b1, 1'b0, 1'b0, 2'b00, 32'h90, 32'h0, 32'h0, TIMEOUT,
               32'h8C22_0004, 32'hFFFF_FF80, 1'b1);
    run_access("sticky1", 1'b1, 1'b0, 1'b1, 2'b00, 32'h94, 32'h0, 32'h0123_4567, 0,
               32'h0123_4567, 32'hFFFF_FF80, 1'b1);
    run_access("sticky2", 1'b1, 1'b0, 1'b0, 2'b01, 32'h97, 32'h0, 32'h0000_0011, 2,
               32'h0123_4567, 32'h0000_0011, 1'b1);

    // Reset mid-access, then a stray ack that must be ignored.
    rd_req = 1'b1; irwrite = 1'b1; lb = 2'b00; addr = 32'h80;
    @(negedge clk);
    check("rstbusy_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstbusy_req0",  32'(mem_req), 32'd0);
    check("rstbusy_instr", instr,        32'd0);
    check("rstbusy_data",  data,         32'd0);
    check("rstbusy_err",   32'(err),     32'd0);
    check("rstbusy_stall", 32'(stall),   32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_req",   32'(mem_req), 32'd0);
    check("stray_instr", instr,        32'd0);
    check("stray_data",  data,         32'd0);
    run_access("post_rst", 1'b1, 1'b0, 1'b1, 2'b00, 32'hA0, 32'h0, 32'hAABB_CCDD, 0,
               32'hAABB_CCDD, 32'h0, 1'b0);
    run_access("both", 1'b1, 1'b1, 1'b0, 2'b00, 32'h60, 32'h1111_2222, 32'h3333_4444, 1,
               32'hAABB_CCDD, 32'h0, 1'b1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_err", 32'(err), 32'd0);

    // Randomized accesses against the behavioural model.
    m_err = 1'b0; m_instr = '0; m_data = '0;
    for (int n = 0; n < 60; n++) begin
      kind    = $urandom_range(0, 9);
      r_rd    = (kind <= 6) || (kind == 9);
      r_wr    = (kind >= 7);
      r_irw   = 1'($urandom_range(0, 1));
      r_lb    = 2'($urandom_range(0, 3));
      r_a     = $urandom();
      r_wd    = $urandom();
      r_rdat  = $urandom();
      r_waits = wait_pick[$urandom_range(0, 6)];
      if (r_rd && r_wr) m_err = 1'b1;
      if (r_waits >= TIMEOUT) m_err = 1'b1;
      else if (r_rd && !r_wr) begin
        if (r_irw) m_instr = r_rdat;
        else       m_data  = ref_load(r_rdat, r_a[1:0], r_lb);
      end
      run_access($sformatf("rnd%0d", n), r_rd, r_wr, r_irw, r_lb, r_a, r_wd, r_rdat, r_waits,
                 m_instr, m_data, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle main controller and the unified instruction/data memory.
- Converts the controller's single-cycle read/write strobes into a req/ack memory handshake with variable latency.
- Holds the controller with `stall` until the access completes.
- Owns the instruction register (IR) and memory data register (MDR), and performs LB/LBU byte extraction before the MDR is written.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed 32 for byte extraction).
- TIMEOUT, 15, maximum cycles in BUSY without `mem_ack` before the access aborts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  controller requests a memory read (FETCH/MEMRD/LBURD/LBRD states)
- wr_req  in  1  controller requests a memory write (memwrite)
- irwrite  in  1  read destination: 1 = IR, 0 = MDR
- lb  in  2  load mode: 00 word, 01 LBU, 10 LB, 11 treated as word
- addr  in  AW  byte address (iord-muxed)
- wdata  in  DW  store data
- stall  out  1  controller must hold its state while high
- instr  out  DW  IR contents
- data  out  DW  MDR contents
- err  out  1  sticky timeout flag
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  AW  registered address, word-aligned (addr[1:0] forced 0)
- mem_wdata  out  DW  registered store data
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  access complete, single-cycle pulse

Behaviour:
- Reset (synchronous) puts all registered outputs at 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `instr`, `data`, `err`) and the state at IDLE.
- Reset mid-access abandons the transaction; `mem_req` is 0 after that edge.
- States are IDLE, BUSY, DONE.
- IDLE:
  - `stall` = rd_req | wr_req, combinational.
  - On a request, latch addr, wdata, irwrite, lb, addr[1:0], and we = wr_req.
  - In the same edge set `mem_req`=1 and go to BUSY.
  - If rd_req and wr_req are both high, the write wins, the read is dropped, and `err` is set.
- BUSY:
  - `stall`=1; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are held stable.
  - Cycle counter increments every BUSY cycle.
  - On `mem_ack`: `mem_req` goes to 0 at that edge, the read data is captured, and the state moves to DONE.
    - Read with irwrite=1: `instr` <= mem_rdata.
    - Read with irwrite=0: `data` <= extracted value.
    - Write: no register update.
  - If the counter reaches TIMEOUT with no ack: `mem_req` goes to 0, `err` goes to 1 (sticky until reset), IR/MDR are unchanged, and the state moves to DONE.
  - `mem_ack` while in IDLE or DONE is ignored.
- DONE:
  - `stall`=0 for exactly one cycle, so the controller advances at this edge.
  - rd_req/wr_req in DONE are ignored, because they still reflect the old state.
  - Next state is IDLE unconditionally.
- Latency:
  - Request seen in cycle T; `mem_req` high in T+1.
  - With ack in T+1: DONE in T+2, and `instr`/`data` are valid from T+2.
  - Minimum 3 cycles per access; N extra wait cycles add N.
- Byte extraction is big-endian:
  - offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - LBU zero-extends; LB sign-extends bit 7 of the selected byte.
  - Word mode passes mem_rdata unchanged and ignores the offset.
- Counter width is clog2(TIMEOUT+1); it clears on entry to BUSY.

Decomposition:
- Package `mem_access_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - LB mode constants LB_WORD=2'b00, LB_U=2'b01, LB_S=2'b10.
- One combinational sub-module, `byte_extract` (inputs rdata, offset, mode; output 32-bit extended value), which is reused by the datapath if needed.

Test Plan:
- Fetch with rd_req=1, irwrite=1, addr=0x0000_0040, ack in the first BUSY cycle, rdata=0x2008_0005 -> mem_addr=0x40 and mem_req high for 1 cycle; stall high 2 cycles; instr=0x2008_0005 at T+2; data unchanged.
- LB with rd_req=1, irwrite=0, lb=10, addr=0x45, rdata=0x1280_FF34, ack after 3 wait cycles -> mem_addr=0x44; data=0xFFFF_FF80; stall high 5 cycles. Repeat with lb=01 -> data=0x0000_0080.
- SW with wr_req=1, addr=0x50, wdata=0xDEAD_BEEF -> mem_we=1 and mem_wdata=0xDEADBEEF stable until ack; instr/data unchanged; one DONE cycle with stall=0.
- Timeout with no ack after a read request -> mem_req drops after 15 BUSY cycles; err=1 and stays 1 through later good accesses until reset.
- Back-to-back: rd_req held through DONE -> no second access launched; a new rd_req in the following IDLE cycle starts a fresh transaction.
- Reset asserted in BUSY, then ack arrives after reset -> mem_req=0, state IDLE, instr/data=0, and the stray ack is ignored.
